snax_wide_bank_splitter: RTL and testbench

SNAX_WIDE_BANK_SPLITTER -- requirements
Module: snax_wide_bank_splitter

---
 rtl/snax_wide_bank_splitter.sv | 158 +++++++++++++++
 tb/tb_snax_wide_bank_splitter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/snax_wide_bank_splitter.sv
// Splits one wide memory request into per-bank narrow requests and, for reads,
// reassembles the bank words into a single wide response.
module snax_wide_bank_splitter #(
  parameter int unsigned AddrWidth       = 48,
  parameter int unsigned NarrowDataWidth = 32,
  parameter int unsigned WideDataWidth   = 512,
  parameter int unsigned NumBanks        = WideDataWidth / NarrowDataWidth
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  wide_req_valid_i,
  output logic                                  wide_req_ready_o,
  input  logic [AddrWidth-1:0]                  wide_req_addr_i,
  input  logic                                  wide_req_write_i,
  input  logic [WideDataWidth-1:0]              wide_req_data_i,
  input  logic [WideDataWidth/8-1:0]            wide_req_strb_i,
  output logic                                  wide_rsp_valid_o,
  input  logic                                  wide_rsp_ready_i,
  output logic [WideDataWidth-1:0]              wide_rsp_data_o,
  output logic [NumBanks-1:0]                   bank_q_valid_o,
  input  logic [NumBanks-1:0]                   bank_q_ready_i,
  output logic [NumBanks*AddrWidth-1:0]         bank_q_addr_o,
  output logic [NumBanks-1:0]                   bank_q_write_o,
  output logic [NumBanks*NarrowDataWidth-1:0]   bank_q_data_o,
  output logic [NumBanks*NarrowDataWidth/8-1:0] bank_q_strb_o,
  input  logic [NumBanks*NarrowDataWidth-1:0]   bank_p_data_i,
  output logic                                  dma_access_o
);

  localparam int unsigned NarrowBytes = NarrowDataWidth / 8;
  localparam int unsigned WideBytes   = WideDataWidth / 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]               r_state;
  logic [1:0]               w_state_next;
  logic [AddrWidth-1:0]     r_base;
  logic                     r_write;
  logic [WideDataWidth-1:0] r_data;
  logic [WideBytes-1:0]     r_strb;
  logic [WideDataWidth-1:0] r_rsp_data;
  logic [NumBanks-1:0]      r_pending;
  logic [NumBanks-1:0]      r_rd_capture;

  logic                     w_accept;
  logic                     w_issue;
  logic [NumBanks-1:0]      w_bank_valid;
  logic [NumBanks-1:0]      w_bank_fire;
  logic [NumBanks-1:0]      w_pending_after;
  logic [NumBanks-1:0]      w_init_pending;

  assign w_issue         = (r_state == ISSUE);
  assign w_accept        = wide_req_valid_i && (r_state == IDLE);
  assign w_bank_valid    = w_issue ? r_pending : '0;
  assign w_bank_fire     = w_bank_valid & bank_q_ready_i;
  assign w_pending_after = r_pending & ~w_bank_fire;

  // Per-bank request fan-out from the registered wide request
  for (genvar g = 0; g < NumBanks; g++) begin : g_bank
    assign w_init_pending[g] = wide_req_write_i ?
                               (|wide_req_strb_i[g*NarrowBytes +: NarrowBytes]) : 1'b1;
    assign bank_q_addr_o[g*AddrWidth +: AddrWidth] = r_base + AddrWidth'(g * NarrowBytes);
    assign bank_q_data_o[g*NarrowDataWidth +: NarrowDataWidth] =
      r_data[g*NarrowDataWidth +: NarrowDataWidth];
    assign bank_q_strb_o[g*NarrowBytes +: NarrowBytes] = r_strb[g*NarrowBytes +: NarrowBytes];
  end

  assign bank_q_valid_o  = w_bank_valid;
  assign bank_q_write_o  = {NumBanks{r_write}};
  assign wide_rsp_data_o = r_rsp_data;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and handshake/status outputs
  always_comb begin
    w_state_next     = r_state;
    wide_req_ready_o = 1'b0;
    wide_rsp_valid_o = 1'b0;
    dma_access_o     = 1'b1;
    case (r_state)
      IDLE: begin
        wide_req_ready_o = 1'b1;
        dma_access_o     = 1'b0;
        if (wide_req_valid_i) w_state_next = ISSUE;
      end
      ISSUE: begin
        if (w_pending_after == '0) w_state_next = r_write ? IDLE : DRAIN;
      end
      DRAIN: begin
        w_state_next = RESP;
      end
      RESP: begin
        wide_rsp_valid_o = 1'b1;
        if (wide_rsp_ready_i) w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Request capture; base address is aligned down to the wide word
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_base  <= '0;
      r_write <= 1'b0;
      r_data  <= '0;
      r_strb  <= '0;
    end else if (w_accept) begin
      r_base  <= wide_req_addr_i & ~AddrWidth'(WideBytes - 1);
      r_write <= wide_req_write_i;
      r_data  <= wide_req_data_i;
      r_strb  <= wide_req_strb_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pending <= '0;
    end else if (w_accept) begin
      r_pending <= w_init_pending;
    end else if (w_issue) begin
      r_pending <= w_pending_after;
    end
  end

  // Banks answer one cycle after acceptance; remember which ones to latch
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_capture <= '0;
    end else begin
      r_rd_capture <= (w_issue && !r_write) ? w_bank_fire : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rsp_data <= '0;
    end else begin
      for (int i = 0; i < NumBanks; i++) begin
        if (r_rd_capture[i]) begin
          r_rsp_data[i*NarrowDataWidth +: NarrowDataWidth] <=
            bank_p_data_i[i*NarrowDataWidth +: NarrowDataWidth];
        end
      end
    end
  end

endmodule

// File: tb/tb_snax_wide_bank_splitter.sv
// Bench for snax_wide_bank_splitter: table of wide transactions, a bank responder
// model, and a response scoreboard, plus a mid-transaction reset sequence.
module tb_snax_wide_bank_splitter;

  localparam int unsigned AW  = 48;
  localparam int unsigned NW  = 32;
  localparam int unsigned WW  = 512;
  localparam int unsigned NB  = 16;
  localparam int unsigned NBY = 4;
  localparam int unsigned WBY = 64;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              wide_req_valid_i;
  logic              wide_req_ready_o;
  logic [AW-1:0]     wide_req_addr_i;
  logic              wide_req_write_i;
  logic [WW-1:0]     wide_req_data_i;
  logic [WBY-1:0]    wide_req_strb_i;
  logic              wide_rsp_valid_o;
  logic              wide_rsp_ready_i;
  logic [WW-1:0]     wide_rsp_data_o;
  logic [NB-1:0]     bank_q_valid_o;
  logic [NB-1:0]     bank_q_ready_i;
  logic [NB*AW-1:0]  bank_q_addr_o;
  logic [NB-1:0]     bank_q_write_o;
  logic [NB*NW-1:0]  bank_q_data_o;
  logic [NB*NBY-1:0] bank_q_strb_o;
  logic [NB*NW-1:0]  bank_p_data_i = '0;
  logic              dma_access_o;

  snax_wide_bank_splitter dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .wide_req_valid_i (wide_req_valid_i),
    .wide_req_ready_o (wide_req_ready_o),
    .wide_req_addr_i  (wide_req_addr_i),
    .wide_req_write_i (wide_req_write_i),
    .wide_req_data_i  (wide_req_data_i),
    .wide_req_strb_i  (wide_req_strb_i),
    .wide_rsp_valid_o (wide_rsp_valid_o),
    .wide_rsp_ready_i (wide_rsp_ready_i),
    .wide_rsp_data_o  (wide_rsp_data_o),
    .bank_q_valid_o   (bank_q_valid_o),
    .bank_q_ready_i   (bank_q_ready_i),
    .bank_q_addr_o    (bank_q_addr_o),
    .bank_q_write_o   (bank_q_write_o),
    .bank_q_data_o    (bank_q_data_o),
    .bank_q_strb_o    (bank_q_strb_o),
    .bank_p_data_i    (bank_p_data_i),
    .dma_access_o     (dma_access_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [WBY-1:0] strb;
    int            stall_bank;
    int            stall_cycles;
    int            rsp_stall;
    int            exp_lat;
    logic [NB-1:0] exp_mask;
  } vec_t;

  int unsigned    n_tests = 0;
  int unsigned    n_fail  = 0;
  logic [WW-1:0]  exp_q[$];
  logic [AW-1:0]  cur_base  = '0;
  logic [WW-1:0]  cur_data  = '0;
  logic [WBY-1:0] cur_strb  = '0;
  logic           cur_write = 1'b0;
  logic [NB-1:0]  seen_mask = '0;

  function automatic logic [NW-1:0] bank_word(input logic [AW-1:0] a);
    logic [31:0] m;
    m = a[31:0] * 32'h9E37_79B1;
    return m ^ {a[47:32], 16'h5A5A};
  endfunction

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  // Bank responder: read data valid exactly one cycle after acceptance
  always @(posedge clk_i) begin
    for (int i = 0; i < NB; i++) begin
      if (bank_q_valid_o[i] && bank_q_ready_i[i] && !bank_q_write_o[i])
        bank_p_data_i[i*NW +: NW] <= bank_word(bank_q_addr_o[i*AW +: AW]);
      else
        bank_p_data_i[i*NW +: NW] <= 32'hDEAD_BEEF;
    end
  end

  // Monitor: per-bank request contents and wide response scoreboard
  always @(negedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NB; i++) begin
        if (bank_q_valid_o[i]) begin
          check("bank_addr", bank_q_addr_o[i*AW +: AW], cur_base + AW'(i * NBY));
          check("bank_write", bank_q_write_o[i], cur_write);
          if (cur_write) begin
            check("bank_data", bank_q_data_o[i*NW +: NW], cur_data[i*NW +: NW]);
            check("bank_strb", bank_q_strb_o[i*NBY +: NBY], cur_strb[i*NBY +: NBY]);
          end
        end
      end
      seen_mask = seen_mask | bank_q_valid_o;
      if (wide_req_ready_o || wide_rsp_valid_o)
        check("valid_outside_issue", bank_q_valid_o, '0);
      if (wide_rsp_valid_o && wide_rsp_ready_i) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_rsp: got response %0h with none expected", wide_rsp_data_o);
        end else begin
          check("rsp_data", wide_rsp_data_o, exp_q.pop_front());
        end
      end
    end
  end

  task automatic wait_ready();
    int k;
    for (k = 0; k < 20; k++) begin
      if (wide_req_ready_o) break;
      tick();
    end
    if (k == 20) check("wait_ready_timeout", wide_req_ready_o, 1'b1);
  endtask

  task automatic run_vec(input vec_t v);
    logic [WW-1:0] exp;
    int lat;
    logic done;
    wait_ready();
    cur_base  = v.addr & ~AW'(WBY - 1);
    cur_write = v.write;
    cur_strb  = v.strb;
    for (int i = 0; i < NB; i++) cur_data[i*NW +: NW] = $urandom();
    seen_mask = '0;
    wide_req_valid_i = 1'b1;
    wide_req_addr_i  = v.addr;
    wide_req_write_i = v.write;
    wide_req_data_i  = cur_data;
    wide_req_strb_i  = v.strb;
    bank_q_ready_i   = '1;
    if (v.stall_cycles > 0) bank_q_ready_i[v.stall_bank] = 1'b0;
    exp = '0;
    for (int i = 0; i < NB; i++) exp[i*NW +: NW] = bank_word(cur_base + AW'(i * NBY));
    if (!v.write) exp_q.push_back(exp);
    tick();
    wide_req_valid_i = 1'b0;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c > v.stall_cycles) bank_q_ready_i = '1;
      if (v.stall_cycles > 0 && c == 2)
        check("stall_only", bank_q_valid_o, NB'(1) << v.stall_bank);
      done = v.write ? wide_req_ready_o : wide_rsp_valid_o;
      if (done) begin
        lat = c;
        break;
      end
      check("dma_busy", dma_access_o, 1'b1);
      tick();
    end
    check("latency", lat, v.exp_lat);
    check("bank_mask", seen_mask, v.exp_mask);
    if (v.write) begin
      check("wr_dma_idle", dma_access_o, 1'b0);
    end else if (lat != 0) begin
      for (int r = 0; r <= v.rsp_stall; r++) begin
        check("rsp_hold_valid", wide_rsp_valid_o, 1'b1);
        check("rsp_hold_data", wide_rsp_data_o, exp);
        check("rsp_hold_req_ready", wide_req_ready_o, 1'b0);
        check("rsp_hold_dma", dma_access_o, 1'b1);
        if (r < v.rsp_stall) tick();
      end
      wide_rsp_ready_i = 1'b1;
      tick();
      wide_rsp_ready_i = 1'b0;
      check("rsp_done_ready", wide_req_ready_o, 1'b1);
      check("rsp_done_valid", wide_rsp_valid_o, 1'b0);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [AW-1:0] a, input logic [WBY-1:0] s,
                              input int sb, input int sc, input int rs, input int lat,
                              input logic [NB-1:0] m);
    vec_t v;
    v.write = w; v.addr = a; v.strb = s; v.stall_bank = sb; v.stall_cycles = sc;
    v.rsp_stall = rs; v.exp_lat = lat; v.exp_mask = m;
    return v;
  endfunction

  initial begin
    vec_t vecs[8];
    int rsp_seen;
    vecs[0] = mk(1'b0, 48'h0000_0000_1034, '0, 0, 0, 0, 3, 16'hFFFF);
    vecs[1] = mk(1'b0, 48'h0000_0000_2000, '0, 5, 4, 0, 7, 16'hFFFF);
    vecs[2] = mk(1'b1, 48'h0000_0000_3010, 64'h0000_0000_0000_000F, 0, 0, 0, 2, 16'h0001);
    vecs[3] = mk(1'b1, 48'h0000_0000_3400, '0, 0, 0, 0, 2, 16'h0000);
    vecs[4] = mk(1'b0, 48'h0000_ABCD_EF40, '0, 0, 0, 3, 3, 16'hFFFF);
    vecs[5] = mk(1'b1, 48'h0000_0000_5000, '1, 15, 2, 0, 4, 16'hFFFF);
    vecs[6] = mk(1'b1, 48'h0000_0001_6020, 64'hF000_0000_0000_00F0, 0, 0, 0, 2, 16'h8002);
    vecs[7] = mk(1'b0, 48'hFFFF_FFFF_FFFF, '0, 0, 0, 1, 3, 16'hFFFF);

    rst_i = 1'b1;
    wide_req_valid_i = 1'b0;
    wide_req_addr_i  = '0;
    wide_req_write_i = 1'b0;
    wide_req_data_i  = '0;
    wide_req_strb_i  = '0;
    wide_rsp_ready_i = 1'b0;
    bank_q_ready_i   = '1;
    tick(); tick(); tick();
    rst_i = 1'b0;
    check("rst_req_ready", wide_req_ready_o, 1'b1);
    check("rst_rsp_valid", wide_rsp_valid_o, 1'b0);
    check("rst_bank_valid", bank_q_valid_o, '0);
    check("rst_dma", dma_access_o, 1'b0);
    check("rst_rsp_data", wide_rsp_data_o, '0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset while eight banks are still pending on a read
    wait_ready();
    cur_base = 48'h4000; cur_write = 1'b0;
    wide_req_valid_i = 1'b1;
    wide_req_addr_i  = 48'h4000;
    wide_req_write_i = 1'b0;
    bank_q_ready_i   = 16'h00FF;
    tick();
    wide_req_valid_i = 1'b0;
    check("mid_first_issue", bank_q_valid_o, 16'hFFFF);
    tick();
    check("mid_eight_pending", bank_q_valid_o, 16'hFF00);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    bank_q_ready_i = '1;
    check("mid_rst_bank_valid", bank_q_valid_o, '0);
    check("mid_rst_req_ready", wide_req_ready_o, 1'b1);
    check("mid_rst_dma", dma_access_o, 1'b0);
    check("mid_rst_rsp_data", wide_rsp_data_o, '0);
    rsp_seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (wide_rsp_valid_o || bank_q_valid_o != '0) rsp_seen++;
      tick();
    end
    check("mid_rst_quiet", rsp_seen, 0);

    // Traffic still works after the abandoned transaction
    run_vec(vecs[0]);
    check("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
